// File: rtl/button_debouncer.sv
// Purpose: synchronise and debounce raw buttons/switches; emit press, release, repeat and change pulses.
// Latency: DEB_CYCLES+2 edges from a stable raw level to the registered level/pulse outputs.
// Backpressure: none; free-running per-channel logic, every output is a registered level or 1-cycle pulse.
module button_debouncer #(
    parameter int N_BTN         = 5,
    parameter int N_SW          = 6,
    parameter int DEB_CYCLES    = 2000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_SW-1:0]  sw_level,
    output logic [N_SW-1:0]  sw_change
);

    localparam int N_CH    = N_BTN + N_SW;
    localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RPT  = 2'd2;

    logic [N_CH-1:0]  raw_all;
    logic [N_CH-1:0]  lvl_all;
    logic [N_CH-1:0]  flip_all;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;

    // Switches sit above buttons so both share one debouncer array.
    assign raw_all = {sw_raw, btn_raw};

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_deb
            logic             s1;
            logic             s2;
            logic             lvl;
            logic [DEB_W-1:0] cnt;

            always_ff @(posedge sys_clk) begin
                if (!rst) begin
                    s1  <= 1'b0;
                    s2  <= 1'b0;
                    lvl <= 1'b0;
                    cnt <= '0;
                end else begin
                    s1 <= raw_all[gi];
                    s2 <= s1;
                    if (s2 == lvl) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        lvl <= s2;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + DEB_W'(1);
                    end
                end
            end

            assign lvl_all[gi]  = lvl;
            // High on the edge that will load the new level.
            assign flip_all[gi] = (s2 != lvl) && (cnt == DEB_LAST);
        end
    endgenerate

    assign btn_rise  = flip_all[N_BTN-1:0] & ~lvl_all[N_BTN-1:0];
    assign btn_fall  = flip_all[N_BTN-1:0] &  lvl_all[N_BTN-1:0];
    assign btn_level = lvl_all[N_BTN-1:0];
    assign sw_level  = lvl_all[N_CH-1:N_BTN];

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            btn_press   <= '0;
            btn_release <= '0;
            sw_change   <= '0;
        end else begin
            btn_press   <= btn_rise;
            btn_release <= btn_fall;
            sw_change   <= flip_all[N_CH-1:N_BTN];
        end
    end

    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_rpt
            logic [1:0]       st;
            logic [RPT_W-1:0] t;
            logic             rpt_q;

            // The FSM reacts on the same edge as the level update, so WAIT starts
            // counting in the press-pulse cycle; release always beats a repeat.
            always_ff @(posedge sys_clk) begin
                if (!rst) begin
                    st    <= ST_IDLE;
                    t     <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    case (st)
                        ST_IDLE: begin
                            if (btn_rise[gi]) begin
                                st <= ST_WAIT;
                                t  <= '0;
                            end
                        end
                        ST_WAIT: begin
                            if (btn_fall[gi]) begin
                                st <= ST_IDLE;
                                t  <= '0;
                            end else if (t == DELAY_LAST) begin
                                rpt_q <= 1'b1;
                                st    <= ST_RPT;
                                t     <= '0;
                            end else begin
                                t <= t + RPT_W'(1);
                            end
                        end
                        ST_RPT: begin
                            if (btn_fall[gi]) begin
                                st <= ST_IDLE;
                                t  <= '0;
                            end else if (t == PERIOD_LAST) begin
                                rpt_q <= 1'b1;
                                t     <= '0;
                            end else begin
                                t <= t + RPT_W'(1);
                            end
                        end
                        default: begin
                            st <= ST_IDLE;
                            t  <= '0;
                        end
                    endcase
                end
            end

            assign btn_repeat[gi] = rpt_q;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: table-driven holds plus hand sequences, pulses matched against an expected-event queue.
module tb_button_debouncer;

    localparam int N_BTN = 5;
    localparam int N_SW  = 6;
    localparam int DEB   = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;
    localparam int LAT   = DEB + 2;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_RPT   = 2;
    localparam int K_CHG   = 3;
    localparam int K_BLVL  = 4;
    localparam int K_SLVL  = 5;

    typedef struct {
        int cyc;
        int kind;
        int ch;
        int val;
    } ev_t;

    typedef struct {
        int ch;
        bit is_sw;
        int hold;
        int exp_rpt;
    } row_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_change;

    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  rpt_seen = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    button_debouncer #(
        .N_BTN(N_BTN), .N_SW(N_SW), .DEB_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .sys_clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .sw_level(sw_level), .sw_change(sw_change)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input int k, input int ch, input int v);
        ev_t e;
        e.cyc = c; e.kind = k; e.ch = ch; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic match_pulse(input int k, input int ch);
        bit found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].cyc == cyc && exp_q[i].kind == k && exp_q[i].ch == ch) begin
                exp_q.delete(i);
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL unexpected pulse kind %0d ch %0d at cyc %0d (no matching expectation)", k, ch, cyc);
        end
    endtask

    // Pulses are matched against the queue; level samples due this cycle are compared.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < N_BTN; c++) begin
                if (btn_press[c] === 1'b1)   match_pulse(K_PRESS, c);
                if (btn_release[c] === 1'b1) match_pulse(K_REL, c);
                if (btn_repeat[c] === 1'b1) begin
                    rpt_seen++;
                    match_pulse(K_RPT, c);
                end
            end
            for (int c = 0; c < N_SW; c++)
                if (sw_change[c] === 1'b1) match_pulse(K_CHG, c);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc && exp_q[i].kind >= K_BLVL) begin
                    if (exp_q[i].kind == K_BLVL)
                        chk($sformatf("btn_level[%0d]", exp_q[i].ch), 32'(btn_level[exp_q[i].ch]), 32'(exp_q[i].val));
                    else
                        chk($sformatf("sw_level[%0d]", exp_q[i].ch), 32'(sw_level[exp_q[i].ch]), 32'(exp_q[i].val));
                    exp_q.delete(i);
                end
            end
        end
    end

    // Raw rises while cyc==r and falls while cyc==f.
    task automatic expect_hold(input int ch, input bit is_sw, input int r, input int f);
        int p = r + LAT;
        int rel = f + LAT;
        if (is_sw) begin
            push(p, K_CHG, ch, 0);
            push(rel, K_CHG, ch, 0);
            push(p - 1, K_SLVL, ch, 0);
            push(p, K_SLVL, ch, 1);
            push(rel - 1, K_SLVL, ch, 1);
            push(rel, K_SLVL, ch, 0);
        end else begin
            push(p, K_PRESS, ch, 0);
            push(rel, K_REL, ch, 0);
            push(p - 1, K_BLVL, ch, 0);
            push(p, K_BLVL, ch, 1);
            push(rel - 1, K_BLVL, ch, 1);
            push(rel, K_BLVL, ch, 0);
            for (int t = p + RD; t < rel; t += RP)
                push(t, K_RPT, ch, 0);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_missing(input string tag);
        while (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL %s missing event kind %0d ch %0d due cyc %0d (not observed)",
                     tag, exp_q[0].kind, exp_q[0].ch, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " btn_level"}, 32'(btn_level), 32'd0);
        chk({tag, " btn_press"}, 32'(btn_press), 32'd0);
        chk({tag, " btn_release"}, 32'(btn_release), 32'd0);
        chk({tag, " btn_repeat"}, 32'(btn_repeat), 32'd0);
        chk({tag, " sw_level"}, 32'(sw_level), 32'd0);
        chk({tag, " sw_change"}, 32'(sw_change), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        row_t rows[4];
        int   r;
        int   base;

        rows[0] = '{ch: 0, is_sw: 1'b0, hold: 20, exp_rpt: 4};
        rows[1] = '{ch: 0, is_sw: 1'b0, hold: 8,  exp_rpt: 0};
        rows[2] = '{ch: 2, is_sw: 1'b0, hold: 40, exp_rpt: 10};
        rows[3] = '{ch: 3, is_sw: 1'b1, hold: 10, exp_rpt: 0};

        rst = 1'b0;
        btn_raw = '0;
        sw_raw = '0;
        step(3);
        chk_all_zero("reset");
        rst = 1'b1;
        mon_en = 1'b1;
        step(3);

        for (int i = 0; i < 4; i++) begin
            rpt_seen = 0;
            r = cyc;
            if (rows[i].is_sw) sw_raw[rows[i].ch] = 1'b1;
            else               btn_raw[rows[i].ch] = 1'b1;
            expect_hold(rows[i].ch, rows[i].is_sw, r, r + rows[i].hold);
            step(rows[i].hold);
            if (rows[i].is_sw) sw_raw[rows[i].ch] = 1'b0;
            else               btn_raw[rows[i].ch] = 1'b0;
            step(LAT + 4);
            drain_missing($sformatf("row%0d", i));
            chk($sformatf("row%0d repeat count", i), 32'(rpt_seen), 32'(rows[i].exp_rpt));
        end

        // Bounce: high runs of 2 and 3 cycles must be rejected.
        btn_raw[1] = 1'b1; step(2);
        btn_raw[1] = 1'b0; step(1);
        btn_raw[1] = 1'b1; step(3);
        btn_raw[1] = 1'b0; step(2);
        btn_raw[1] = 1'b1;
        r = cyc;
        expect_hold(1, 1'b0, r, r + 6);
        step(6);
        btn_raw[1] = 1'b0;
        step(LAT + 4);
        drain_missing("bounce");

        // Reset while button 4 is in WAIT, raw held high through reset.
        r = cyc;
        btn_raw[4] = 1'b1;
        push(r + LAT, K_PRESS, 4, 0);
        push(r + LAT, K_BLVL, 4, 1);
        step(10);
        rst = 1'b0;
        step(1);
        chk_all_zero("mid-reset");
        drain_missing("pre-reset");
        rst = 1'b1;
        r = cyc;
        expect_hold(4, 1'b0, r, r + 25);
        step(25);
        btn_raw[4] = 1'b0;
        step(LAT + 4);
        drain_missing("post-reset");

        // All buttons, staggered one cycle apart.
        base = cyc;
        for (int i = 0; i < N_BTN; i++) begin
            btn_raw[i] = 1'b1;
            expect_hold(i, 1'b0, base + i, base + i + 12);
            step(1);
        end
        step(7);
        for (int i = 0; i < N_BTN; i++) begin
            btn_raw[i] = 1'b0;
            step(1);
        end
        step(LAT + 4);
        drain_missing("stagger");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
